// File: rtl/simd_mac_accumulator.sv
// simd_mac_accumulator
//   Three-stage SIMD multiply-accumulate. Operands are split into 1, 2 or 4
//   lanes by mode; each lane's exact product is accumulated over a framed
//   burst of beats. The addend x and carry-in cin are applied on the start
//   beat only. No carry ever crosses a lane boundary.
//
//   Handshake: in_valid qualifies a beat in the cycle it is high; there is no
//   ready, every valid beat is accepted. out_valid is a single-cycle pulse in
//   the cycle s/carry/mode_err take new values; they hold until the next pulse.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low
//   mode       lane split: 0 = 1xW, 1 = 2xW/2, 2 = 4xW/4, 3 = same as 0
//   in_valid   beat present
//   first      beat opens an accumulation
//   last       beat closes an accumulation
//   a, b       W-bit operands, lane k at [kL+L-1:kL]
//   a_sign     all a lanes signed
//   b_sign     all b lanes signed
//   x          2W-bit addend, lane k at [2kL+2L-1:2kL], start beat only
//   cin        added at each lane LSB, start beat only
//   out_valid  result pulse
//   s          accumulated result, lane layout as x
//   carry      sticky per-lane unsigned carry-out (unused lanes read 0)
//   mode_err   sticky, a beat was dropped for a mode mismatch
//   dbg_state  accumulator FSM state (1 = ACCUM)
module simd_mac_accumulator #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     mode,
   input  logic           in_valid,
   input  logic           first,
   input  logic           last,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           a_sign,
   input  logic           b_sign,
   input  logic [2*W-1:0] x,
   input  logic           cin,
   output logic           out_valid,
   output logic [2*W-1:0] s,
   output logic [3:0]     carry,
   output logic           mode_err,
   output logic           dbg_state
);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   // ---------------- stage 1: input registers ----------------
   logic           s1_valid, s1_first, s1_last, s1_a_sign, s1_b_sign, s1_cin;
   logic [1:0]     s1_mode;
   logic [W-1:0]   s1_a, s1_b;
   logic [2*W-1:0] s1_x;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_mode   <= 2'd0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_a_sign <= 1'b0;
         s1_b_sign <= 1'b0;
         s1_x      <= '0;
         s1_cin    <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_first  <= first;
            s1_last   <= last;
            // Reserved mode 3 is folded to 0 here so later mode compares
            // see a single encoding for the full-width split.
            s1_mode   <= (mode == 2'd3) ? 2'd0 : mode;
            s1_a      <= a;
            s1_b      <= b;
            s1_a_sign <= a_sign;
            s1_b_sign <= b_sign;
            s1_x      <= x;
            s1_cin    <= cin;
         end
      end
   end

   // ---------------- stage 2: per-lane exact products ----------------
   // One product set per split. Each lane operand is sign- or zero-extended
   // to 2L bits; the 2L-bit product of those is the exact lane product.
   for (genvar m = 0; m < 3; m++) begin : g_mul
      localparam int N = 1 << m;
      localparam int L = W / N;
      logic [2*W-1:0] prod;
      for (genvar k = 0; k < N; k++) begin : g_lane
         logic signed [2*L-1:0] ea, eb, p;
         assign ea = {{L{s1_a_sign & s1_a[k*L+L-1]}}, s1_a[k*L +: L]};
         assign eb = {{L{s1_b_sign & s1_b[k*L+L-1]}}, s1_b[k*L +: L]};
         assign p  = ea * eb;
         assign prod[2*k*L +: 2*L] = p;
      end
   end

   logic [2*W-1:0] prod_sel;
   always_comb begin
      prod_sel = g_mul[0].prod;
      case (s1_mode)
         2'd1:    prod_sel = g_mul[1].prod;
         2'd2:    prod_sel = g_mul[2].prod;
         default: prod_sel = g_mul[0].prod;
      endcase
   end

   logic           s2_valid, s2_first, s2_last, s2_cin;
   logic [1:0]     s2_mode;
   logic [2*W-1:0] s2_prod, s2_x;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_mode  <= 2'd0;
         s2_prod  <= '0;
         s2_x     <= '0;
         s2_cin   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_mode  <= s1_mode;
            s2_prod  <= prod_sel;
            s2_x     <= s1_x;
            s2_cin   <= s1_cin;
         end
      end
   end

   // ---------------- stage 3: lane adders ----------------
   state_t         state, state_nxt;
   logic [1:0]     acc_mode, acc_mode_nxt;
   logic [2*W-1:0] acc, acc_nxt;
   logic [3:0]     acc_cy, acc_cy_nxt;
   logic           acc_err, acc_err_nxt;
   logic           emit;
   logic           start;

   // start_sum = prod + x + cin, accum_sum = acc + prod, lane by lane.
   // A start-beat carry is the OR of the carries of both of its additions.
   for (genvar m = 0; m < 3; m++) begin : g_add
      localparam int N  = 1 << m;
      localparam int LL = (2 * W) / N;
      logic [2*W-1:0] start_sum, accum_sum;
      logic [3:0]     start_cy, accum_cy;
      for (genvar k = 0; k < N; k++) begin : g_lane
         logic [LL:0] t1, t2, t3;
         assign t1 = {1'b0, s2_prod[k*LL +: LL]} + {1'b0, s2_x[k*LL +: LL]};
         assign t2 = {1'b0, t1[LL-1:0]} + {{LL{1'b0}}, s2_cin};
         assign t3 = {1'b0, acc[k*LL +: LL]} + {1'b0, s2_prod[k*LL +: LL]};
         assign start_sum[k*LL +: LL] = t2[LL-1:0];
         assign accum_sum[k*LL +: LL] = t3[LL-1:0];
         assign start_cy[k] = t1[LL] | t2[LL];
         assign accum_cy[k] = t3[LL];
      end
      if (N < 4) begin : g_pad
         assign start_cy[3:N] = '0;
         assign accum_cy[3:N] = '0;
      end
   end

   logic [2*W-1:0] start_sel, accum_sel;
   logic [3:0]     start_cy_sel, accum_cy_sel;
   always_comb begin
      start_sel    = g_add[0].start_sum;
      accum_sel    = g_add[0].accum_sum;
      start_cy_sel = g_add[0].start_cy;
      accum_cy_sel = g_add[0].accum_cy;
      case (s2_mode)
         2'd1: begin
            start_sel    = g_add[1].start_sum;
            accum_sel    = g_add[1].accum_sum;
            start_cy_sel = g_add[1].start_cy;
            accum_cy_sel = g_add[1].accum_cy;
         end
         2'd2: begin
            start_sel    = g_add[2].start_sum;
            accum_sel    = g_add[2].accum_sum;
            start_cy_sel = g_add[2].start_cy;
            accum_cy_sel = g_add[2].accum_cy;
         end
         default: ;
      endcase
   end

   // ---------------- stage 3: accumulator FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      acc_mode_nxt = acc_mode;
      acc_cy_nxt   = acc_cy;
      acc_err_nxt  = acc_err;
      emit         = 1'b0;
      // Any valid beat in IDLE starts, so a frame missing its first still
      // produces a sensible result; first in ACCUM discards the partial.
      start        = s2_valid & (s2_first | (state == IDLE));
      if (s2_valid) begin
         if (start) begin
            acc_nxt      = start_sel;
            acc_cy_nxt   = start_cy_sel;
            acc_err_nxt  = 1'b0;
            acc_mode_nxt = s2_mode;
         end else if (s2_mode == acc_mode) begin
            acc_nxt    = accum_sel;
            acc_cy_nxt = acc_cy | accum_cy_sel;
         end else begin
            acc_err_nxt = 1'b1;
         end
         if (s2_last) begin
            emit      = 1'b1;
            state_nxt = IDLE;
         end else begin
            state_nxt = ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= '0;
         acc_mode  <= 2'd0;
         acc_cy    <= 4'd0;
         acc_err   <= 1'b0;
         out_valid <= 1'b0;
         s         <= '0;
         carry     <= 4'd0;
         mode_err  <= 1'b0;
      end else begin
         acc       <= acc_nxt;
         acc_mode  <= acc_mode_nxt;
         acc_cy    <= acc_cy_nxt;
         acc_err   <= acc_err_nxt;
         out_valid <= emit;
         if (emit) begin
            s        <= acc_nxt;
            carry    <= acc_cy_nxt;
            mode_err <= acc_err_nxt;
         end
      end
   end

   assign dbg_state = (state == ACCUM);

endmodule

// File: tb/tb_simd_mac_accumulator.sv
// Testbench for simd_mac_accumulator (W = 32). A reference model works on
// lane values as plain integers; its expected output word for every cycle is
// queued and compared three clock edges later against the DUT.
module tb_simd_mac_accumulator;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]     mode;
   logic           in_valid, first, last, a_sign, b_sign, cin;
   logic [W-1:0]   a, b;
   logic [2*W-1:0] x;
   logic           out_valid, mode_err, dbg_state;
   logic [2*W-1:0] s;
   logic [3:0]     carry;

   simd_mac_accumulator #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .in_valid  (in_valid),
      .first     (first),
      .last      (last),
      .a         (a),
      .b         (b),
      .a_sign    (a_sign),
      .b_sign    (b_sign),
      .x         (x),
      .cin       (cin),
      .out_valid (out_valid),
      .s         (s),
      .carry     (carry),
      .mode_err  (mode_err),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   // Entry layout: {out_valid, s[63:0], carry[3:0], mode_err}
   logic [69:0] exp_q[$];
   int total_cnt  = 0;
   int passed_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total_cnt++;
      assert (obs === expv) passed_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // ---------------- reference model ----------------
   bit          m_in_acc;
   logic [1:0]  m_mode;
   logic [63:0] m_acc, o_s;
   logic [3:0]  m_cy, o_cy;
   logic        m_err, o_err;

   function automatic logic [67:0] lane_prod(input logic [31:0] av, input logic [31:0] bv,
                                             input logic as, input logic bs,
                                             input int k, input int L);
      logic [67:0] au, bu, lm;
      logic signed [67:0] sa, sb, p;
      lm = 68'd1 << L;
      au = (68'(av) >> (k * L)) % lm;
      bu = (68'(bv) >> (k * L)) % lm;
      sa = $signed(au);
      sb = $signed(bu);
      if (as && au[L-1]) sa = sa - $signed(lm);
      if (bs && bu[L-1]) sb = sb - $signed(lm);
      p = sa * sb;
      return $unsigned(p) % (68'd1 << (2 * L));
   endfunction

   task automatic model_reset();
      m_in_acc = 0;
      m_mode   = 2'd0;
      m_acc    = '0;
      m_cy     = '0;
      m_err    = 1'b0;
      o_s      = '0;
      o_cy     = '0;
      o_err    = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
   endtask

   task automatic model_step(input logic v, input logic f, input logic l, input logic [1:0] md,
                             input logic [31:0] av, input logic [31:0] bv, input logic as,
                             input logic bs, input logic [63:0] xv, input logic c,
                             output logic [69:0] e);
      logic        ov;
      logic [1:0]  me;
      int          n, L;
      logic [67:0] lmod, p, t, ln;
      logic [63:0] nacc;
      logic        cy;
      ov = 1'b0;
      if (v) begin
         me   = (md == 2'd3) ? 2'd0 : md;
         n    = 1 << me;
         L    = 32 / n;
         lmod = 68'd1 << (2 * L);
         if (f || !m_in_acc) begin
            nacc = '0;
            m_cy = '0;
            for (int k = 0; k < n; k++) begin
               p  = lane_prod(av, bv, as, bs, k, L);
               ln = (68'(xv) >> (k * 2 * L)) % lmod;
               t  = p + ln;
               cy = (t >= lmod);
               t  = (t % lmod) + 68'(c);
               cy = cy | (t >= lmod);
               t  = t % lmod;
               nacc = nacc | 64'(t << (k * 2 * L));
               m_cy[k] = cy;
            end
            m_acc    = nacc;
            m_err    = 1'b0;
            m_mode   = me;
            m_in_acc = 1;
         end else if (me == m_mode) begin
            nacc = '0;
            for (int k = 0; k < n; k++) begin
               p  = lane_prod(av, bv, as, bs, k, L);
               ln = (68'(m_acc) >> (k * 2 * L)) % lmod;
               t  = ln + p;
               if (t >= lmod) m_cy[k] = 1'b1;
               t  = t % lmod;
               nacc = nacc | 64'(t << (k * 2 * L));
            end
            m_acc = nacc;
         end else begin
            m_err = 1'b1;
         end
         if (l) begin
            o_s      = m_acc;
            o_cy     = m_cy;
            o_err    = m_err;
            ov       = 1'b1;
            m_in_acc = 0;
         end
      end
      e = {ov, o_s, o_cy, o_err};
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic f, input logic l, input logic [1:0] md,
                        input logic [31:0] av, input logic [31:0] bv, input logic as,
                        input logic bs, input logic [63:0] xv, input logic c);
      logic [69:0] e;
      in_valid = v;
      first    = f;
      last     = l;
      mode     = md;
      a        = av;
      b        = bv;
      a_sign   = as;
      b_sign   = bs;
      x        = xv;
      cin      = c;
      model_step(v, f, l, md, av, bv, as, bs, xv, c, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk("out_valid", {63'd0, out_valid}, {63'd0, e[69]});
         chk("s", s, e[68:5]);
         chk("carry", {60'd0, carry}, {60'd0, e[4:1]});
         chk("mode_err", {63'd0, mode_err}, {63'd0, e[0]});
      end
   endtask

   // Idle cycles carry random junk on the data inputs with in_valid low.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, 1'($urandom_range(0, 1)));
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_8080;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] cur_mode, md;
      reset    = 1'b0;
      in_valid = 1'b0;
      first    = 1'b0;
      last     = 1'b0;
      mode     = 2'd0;
      a        = '0;
      b        = '0;
      a_sign   = 1'b0;
      b_sign   = 1'b0;
      x        = '0;
      cin      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_s", s, 64'd0);
      chk("rst_carry", {60'd0, carry}, 64'd0);
      chk("rst_mode_err", {63'd0, mode_err}, 64'd0);
      reset = 1'b1;
      model_reset();

      // mode 0 unsigned single-beat frame
      drive(1, 1, 1, 2'd0, 32'd3, 32'd5, 0, 0, 64'd7, 1);
      idle(2);
      chk("t1_valid", {63'd0, out_valid}, 64'd1);
      chk("t1_s", s, 64'h17);
      chk("t1_carry", {60'd0, carry}, 64'd0);
      idle(1);

      // mode 1 signed
      drive(1, 1, 1, 2'd1, {16'hFFFF, 16'd2}, {16'd3, 16'd4}, 1, 1, 64'd0, 0);
      idle(2);
      chk("t2_s", s, 64'hFFFFFFFD_00000008);

      // mode 2 four-beat accumulation
      drive(1, 1, 0, 2'd2, 32'h01010101, 32'h02020202, 0, 0, 64'd0, 0);
      drive(1, 0, 0, 2'd2, 32'h01010101, 32'h02020202, 0, 0, 64'd0, 0);
      drive(1, 0, 0, 2'd2, 32'h01010101, 32'h02020202, 0, 0, 64'd0, 0);
      drive(1, 0, 1, 2'd2, 32'h01010101, 32'h02020202, 0, 0, 64'd0, 0);
      idle(2);
      chk("t3_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_s", s, 64'h0008_0008_0008_0008);

      // carry-out and its clearing by the next start beat
      drive(1, 1, 1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'h2000000000000000, 0);
      idle(2);
      chk("t4_s", s, 64'h1FFFFFFE00000001);
      chk("t4_carry", {60'd0, carry}, 64'd1);
      drive(1, 1, 1, 2'd0, 32'd0, 32'd0, 0, 0, 64'd0, 0);
      idle(2);
      chk("t4_carry_clr", {60'd0, carry}, 64'd0);

      // mode mismatch drops the beat and flags mode_err
      drive(1, 1, 0, 2'd1, 32'h00030002, 32'h00050004, 0, 0, 64'd0, 0);
      drive(1, 0, 1, 2'd2, 32'h11111111, 32'h22222222, 0, 0, 64'd0, 0);
      idle(2);
      chk("t5_s", s, 64'h0000000F_00000008);
      chk("t5_err", {63'd0, mode_err}, 64'd1);
      drive(1, 1, 1, 2'd0, 32'd1, 32'd1, 0, 0, 64'd0, 0);
      idle(2);
      chk("t5_err_clr", {63'd0, mode_err}, 64'd0);
      chk("t5_s2", s, 64'd1);

      // restart by first mid-frame, then a frame opened without first
      drive(1, 1, 0, 2'd0, 32'd10, 32'd10, 0, 0, 64'd0, 0);
      drive(1, 1, 0, 2'd0, 32'd2, 32'd2, 0, 0, 64'd0, 0);
      drive(1, 0, 1, 2'd0, 32'd1, 32'd1, 0, 0, 64'd0, 0);
      drive(1, 0, 1, 2'd0, 32'd3, 32'd3, 0, 0, 64'd0, 0);
      idle(1);
      chk("t6_s", s, 64'd5);
      idle(1);
      chk("t6_s2", s, 64'd9);

      // reset in the middle of a frame
      drive(1, 1, 0, 2'd0, 32'd1, 32'd1, 0, 0, 64'd0, 0);
      drive(1, 0, 0, 2'd0, 32'd1, 32'd1, 0, 0, 64'd0, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_s", s, 64'd0);
      chk("mid_rst_carry", {60'd0, carry}, 64'd0);
      chk("mid_rst_err", {63'd0, mode_err}, 64'd0);
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_valid2", {63'd0, out_valid}, 64'd0);
      reset = 1'b1;
      model_reset();
      drive(1, 0, 1, 2'd0, 32'd2, 32'd3, 0, 0, 64'd0, 0);
      idle(2);
      chk("t7_valid", {63'd0, out_valid}, 64'd1);
      chk("t7_s", s, 64'd6);

      // randomized frames against the model
      cur_mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < 400; i++) begin
         logic f;
         f = ($urandom_range(0, 5) == 0);
         if (f && $urandom_range(0, 1) == 1) cur_mode = 2'($urandom_range(0, 3));
         md = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : cur_mode;
         drive(1'($urandom_range(0, 3) != 0), f, 1'($urandom_range(0, 4) == 0), md,
               pick_op(), pick_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {pick_op(), pick_op()}, 1'($urandom_range(0, 1)));
      end
      idle(4);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
